// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, driven by an
// IDLE/RUN/DONE controller whose outputs are all registered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shiftA_q;
  logic [WIDTH-1:0] shiftB_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             dBit;
  logic             br_d;
  logic [WIDTH-1:0] shiftA_d;

  // The minuend register doubles as the result accumulator: each consumed
  // LSB makes room at the top for the freshly computed difference bit.
  always_comb begin
    dBit     = shiftA_q[0] ^ shiftB_q[0] ^ br_q;
    br_d     = (~shiftA_q[0] & shiftB_q[0]) | (~(shiftA_q[0] ^ shiftB_q[0]) & br_q);
    shiftA_d = {dBit, shiftA_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shiftA_q <= '0;
      shiftB_q <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shiftA_q <= a;
            shiftB_q <= b;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          shiftA_q <= shiftA_d;
          shiftB_q <= {1'b0, shiftB_q[WIDTH-1:1]};
          br_q     <= br_d;
          if (cnt_q == LAST) begin
            diff_q  <= shiftA_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a cycle-countdown reference model
// checked every cycle, plus directed operations with literal expected results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int cmpCount = 0;
  int errCount = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: an operation occupies WIDTH+1 cycles after its accepting
  // edge; the last of those is the done cycle, when the result appears.
  int           remaining = 0;
  logic [W-1:0] capA = '0;
  logic [W-1:0] capB = '0;
  logic [W-1:0] mDiff = '0;
  logic         mBout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining = 0;
      mDiff     = '0;
      mBout     = 1'b0;
    end else if (remaining == 0) begin
      if (start === 1'b1) begin
        capA      = a;
        capB      = b;
        remaining = W + 1;
      end
    end else begin
      remaining--;
      if (remaining == 1) begin
        mDiff = W'(capA - capB);
        mBout = (capA < capB);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model busy", {31'd0, busy}, {31'd0, remaining > 0});
    checkOutput("model done", {31'd0, done}, {31'd0, remaining == 1});
    checkOutput("model diff", {24'd0, diff}, {24'd0, mDiff});
    checkOutput("model bout", {31'd0, bout}, {31'd0, mBout});
  end

  // One start pulse, operands scrambled after acceptance, bounded wait for done.
  task automatic applyStimulus(input string name, input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input logic [W-1:0] expDiff, input logic expBout);
    int k;
    bit seen;
    @(negedge clk);
    a = opA;
    b = opB;
    start = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        a = ~opA;
        b = opB ^ 8'h5A;
      end
      if (done) seen = 1;
    end
    checkOutput({name, " done seen"}, {31'd0, seen}, 32'd1);
    checkOutput({name, " latency"}, k, 32'd9);
    checkOutput({name, " diff"}, {24'd0, diff}, {24'd0, expDiff});
    checkOutput({name, " bout"}, {31'd0, bout}, {31'd0, expBout});
  endtask

  task automatic countDone(input string name, input int cycles, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    checkOutput({name, " done count"}, n, exp);
  endtask

  logic [W-1:0] holdA[3]    = '{8'h10, 8'h01, 8'h80};
  logic [W-1:0] holdB[3]    = '{8'h01, 8'h02, 8'h7F};
  logic [W-1:0] holdDiff[3] = '{8'h0F, 8'hFF, 8'h01};
  logic         holdBout[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int k;
    bit seen;
    int doneCnt;
    int lastDone;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #3;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset diff", {24'd0, diff}, 32'd0);
    checkOutput("reset bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("5-3", 8'h05, 8'h03, 8'h02, 1'b0);
    applyStimulus("3-5", 8'h03, 8'h05, 8'hFE, 1'b1);
    applyStimulus("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1);
    applyStimulus("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    applyStimulus("00-00", 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus("FF-00", 8'hFF, 8'h00, 8'hFF, 1'b0);

    // Second start during RUN must be ignored.
    @(negedge clk);
    a = 8'h20;
    b = 8'h01;
    start = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (k == 3) begin
        start = 1'b1;
        a = 8'h01;
        b = 8'h20;
      end
      if (k == 4) start = 1'b0;
      if (done) seen = 1;
    end
    checkOutput("repulse done seen", {31'd0, seen}, 32'd1);
    checkOutput("repulse latency", k, 32'd9);
    checkOutput("repulse diff", {24'd0, diff}, 32'h1F);
    checkOutput("repulse bout", {31'd0, bout}, 32'd0);
    countDone("repulse after", 12, 0);

    // Reset asserted just after the 4th RUN edge.
    @(negedge clk);
    a = 8'h77;
    b = 8'h11;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset done", {31'd0, done}, 32'd0);
    checkOutput("midreset diff", {24'd0, diff}, 32'd0);
    checkOutput("midreset bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    countDone("after reset", 12, 0);
    applyStimulus("9-4", 8'h09, 8'h04, 8'h05, 1'b0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    a = holdA[0];
    b = holdB[0];
    start = 1'b1;
    doneCnt = 0;
    lastDone = 0;
    for (int cyc = 1; cyc <= 40 && doneCnt < 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        checkOutput($sformatf("held op%0d diff", doneCnt), {24'd0, diff}, {24'd0, holdDiff[doneCnt]});
        checkOutput($sformatf("held op%0d bout", doneCnt), {31'd0, bout}, {31'd0, holdBout[doneCnt]});
        if (doneCnt > 0) checkOutput($sformatf("held op%0d spacing", doneCnt), cyc - lastDone, 32'd10);
        lastDone = cyc;
        doneCnt++;
        if (doneCnt < 3) begin
          a = holdA[doneCnt];
          b = holdB[doneCnt];
        end else begin
          start = 1'b0;
        end
      end
    end
    checkOutput("held done count", doneCnt, 32'd3);
    countDone("held tail", 12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
